// File: rtl/instr_fetch.sv
// instr_fetch: PC holder and imem req/ack fetcher feeding decode over valid/ready.
// Define IF_ALIGN_CHECK_EN to trap misaligned redirect targets in FAULT instead of masking bits [1:0].
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_data_o,
  output logic [31:0] pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pend, pend_n, tgt;
  logic kill, kill_n, cap, bad, mis, mis_n;
`ifdef IF_ALIGN_CHECK_EN
  assign tgt = redirect_pc_i;
  assign bad = redirect_valid_i && redirect_pc_i[1:0] != 2'b00;
`else
  assign tgt = {redirect_pc_i[31:2], 2'b00};
  assign bad = 1'b0;
`endif
  assign imem_req_o    = state == REQ;
  assign imem_addr_o   = pc;
  assign instr_valid_o = state == HOLD;
  assign misalign_o    = mis;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    pend_n  = pend;
    mis_n   = mis;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid_i) begin
          pc_n    = tgt;
          mis_n   = mis | bad;
          state_n = bad ? FAULT : REQ;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          kill_n  = 1'b0;
          pc_n    = redirect_valid_i ? tgt : kill ? pend : pc;
          cap     = !kill && !redirect_valid_i;
          mis_n   = mis | bad;
          state_n = (mis || bad) ? FAULT : cap ? HOLD : REQ;
        end else if (redirect_valid_i) begin
          // request can't be withdrawn: mark its response for discard and remember the target
          kill_n = 1'b1;
          pend_n = tgt;
          mis_n  = mis | bad;
        end
      end
      HOLD: begin
        if (redirect_valid_i) begin
          pc_n    = tgt;
          mis_n   = mis | bad;
          state_n = bad ? FAULT : REQ;
        end else if (instr_ready_i) begin
          pc_n    = pc_o + 32'd4;
          state_n = REQ;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pend         <= RESET_PC;
      kill         <= 1'b0;
      mis          <= 1'b0;
      instr_data_o <= '0;
      pc_o         <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      pend  <= pend_n;
      kill  <= kill_n;
      mis   <= mis_n;
      if (cap) begin
        instr_data_o <= imem_rdata_i;
        pc_o         <= pc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch with hand-computed expectations.
module tb_instr_fetch;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_data_o;
  logic [31:0] pc_o;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        misalign_o;
  int nvec = 0, nerr = 0, xfers = 0;

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_data_o(instr_data_o), .pc_o(pc_o),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (!rst_i && instr_valid_o && instr_ready_i) xfers++;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    chk("req", {31'b0, imem_req_o}, 32'd1);
    chk("addr", imem_addr_o, a);
    imem_ack_i = 1'b1;
    imem_rdata_i = word(a);
    cyc();
    imem_ack_i = 1'b0;
    chk("valid", {31'b0, instr_valid_o}, 32'd1);
    chk("pc_o", pc_o, a);
    chk("data", instr_data_o, word(a));
    chk("req_in_hold", {31'b0, imem_req_o}, 32'd0);
  endtask

  task automatic consume();
    instr_ready_i = 1'b1;
    cyc();
    instr_ready_i = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t, input logic rdy, input logic ack);
    redirect_valid_i = 1'b1;
    redirect_pc_i = t;
    instr_ready_i = rdy;
    imem_ack_i = ack;
    imem_rdata_i = word(imem_addr_o);
    cyc();
    redirect_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    imem_ack_i = 1'b0;
  endtask

  initial begin
    cyc();
    imem_ack_i = 1'b1;
    cyc();
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_data", instr_data_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    imem_ack_i = 1'b0;
    rst_i = 1'b0;
    cyc();
    fetch(32'h0); consume();
    fetch(32'h4); consume();
    fetch(32'h8);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", {31'b0, instr_valid_o}, 32'd1);
      chk("bp_pc", pc_o, 32'h8);
      chk("bp_data", instr_data_o, word(32'h8));
      chk("bp_req", {31'b0, imem_req_o}, 32'd0);
    end
    consume();
    fetch(32'hC); consume();
    chk("ws_addr0", imem_addr_o, 32'h10);
    redirect(32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'b0, imem_req_o}, 32'd1);
      chk("ws_addr", imem_addr_o, 32'h10);
      if (i < 2) cyc();
    end
    imem_ack_i = 1'b1;
    imem_rdata_i = word(32'h10);
    cyc();
    imem_ack_i = 1'b0;
    chk("ws_drop", {31'b0, instr_valid_o}, 32'd0);
    fetch(32'h40);
    redirect(32'h20, 1'b0, 1'b0);
    chk("hold_redir_valid", {31'b0, instr_valid_o}, 32'd0);
    fetch(32'h20);
    chk("xfers_before", xfers, 32'd4);
    redirect(32'h100, 1'b1, 1'b0);
    chk("rr_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("xfers_after", xfers, 32'd5);
    fetch(32'h100);
    redirect(32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch(32'hFFFF_FFFC); consume();
    chk("wrap_addr", imem_addr_o, 32'h0);
    chk("wrap_req", {31'b0, imem_req_o}, 32'd1);
    redirect(32'h200, 1'b0, 1'b1);
    chk("ack_redir_valid", {31'b0, instr_valid_o}, 32'd0);
    fetch(32'h200);
    redirect(32'h102, 1'b0, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_set", {31'b0, misalign_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      imem_ack_i = 1'b1;
      instr_ready_i = 1'b1;
      chk("fault_req", {31'b0, imem_req_o}, 32'd0);
      chk("fault_valid", {31'b0, instr_valid_o}, 32'd0);
      cyc();
    end
    imem_ack_i = 1'b0;
    instr_ready_i = 1'b0;
`else
    chk("mis_tied", {31'b0, misalign_o}, 32'd0);
    fetch(32'h100);
`endif
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    cyc();
    imem_ack_i = 1'b0;
    chk("rst2_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst2_addr", imem_addr_o, 32'h0);
    chk("rst2_mis", {31'b0, misalign_o}, 32'd0);
    rst_i = 1'b0;
    cyc();
    fetch(32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
